// File: rtl/phy_arb_pkg.sv
// Shared state encoding, default bit-time constants and sizing helpers
// for the full-speed PHY arbiter and its neighbouring PHY blocks.
package phy_arb_pkg;

  typedef enum logic [2:0] {
    ST_OFF  = 3'd0,
    ST_IDLE = 3'd1,
    ST_RX   = 3'd2,
    ST_TX   = 3'd3,
    ST_TURN = 3'd4,
    ST_WAIT = 3'd5
  } arb_state_e;

  localparam int IPD_BITS_DEF     = 2;
  localparam int TURN_BITS_DEF    = 1;
  localparam int TIMEOUT_BITS_DEF = 18;

  // Number of bits needed to hold values 0 .. value-1.
  function automatic int ceil_log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/phy_bit_timer.sv
// Saturating bit-time counter advanced once per gated clock period.
module phy_bit_timer #(
  parameter int W = 5
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] sat_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q < sat_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/phy_arb.sv
// Half-duplex bus sequencer between the full-speed receiver and transmitter:
// gates the receiver, grants the bus to the SIE, and times inter-packet gaps.
module phy_arb
  import phy_arb_pkg::*;
#(
  parameter int IPD_BITS     = IPD_BITS_DEF,
  parameter int TURN_BITS    = TURN_BITS_DEF,
  parameter int TIMEOUT_BITS = TIMEOUT_BITS_DEF
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clk_gate_i,
  input  logic enable_i,
  input  logic bus_reset_i,
  output logic rx_en_o,
  input  logic rx_ready_i,
  input  logic rx_valid_i,
  input  logic rx_err_i,
  input  logic tx_req_i,
  input  logic expect_rsp_i,
  output logic tx_grant_o,
  input  logic tx_done_i,
  output logic rx_active_o,
  output logic rx_timeout_o
);

  localparam int CNT_MAX  = max3(IPD_BITS, TURN_BITS, TIMEOUT_BITS);
  localparam int CNT_W_RAW = ceil_log2(CNT_MAX + 1);
  localparam int CNT_W    = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;

  localparam logic [CNT_W-1:0] IPD_C          = CNT_W'(IPD_BITS);
  localparam logic [CNT_W-1:0] TURN_LAST_C    = CNT_W'(TURN_BITS - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST_C = CNT_W'(TIMEOUT_BITS - 1);

  arb_state_e       state_q, state_d;
  logic             exp_q, exp_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] cnt_sat;
  logic             cnt_clr;

  logic rx_eop;
  logic rx_end;
  logic rx_start;
  logic force_off;

  assign rx_eop    = rx_ready_i & ~rx_valid_i & ~rx_err_i;
  assign rx_end    = rx_eop | (rx_ready_i & rx_err_i);
  assign rx_start  = rx_ready_i & rx_valid_i;
  assign force_off = ~enable_i | bus_reset_i;

  // Idle counting stops at the gap length so a late request is granted at once.
  assign cnt_sat = (state_q == ST_IDLE) ? IPD_C : '1;
  assign cnt_clr = (state_d != state_q);

  phy_bit_timer #(
    .W(CNT_W)
  ) u_bit_timer (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .en_i  (clk_gate_i),
    .clr_i (cnt_clr),
    .sat_i (cnt_sat),
    .cnt_o (bit_cnt)
  );

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    timeout_d = 1'b0;

    case (state_q)
      ST_OFF: begin
        if (enable_i && !bus_reset_i) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (rx_start) begin
          state_d = ST_RX;
        end else if (tx_req_i && (bit_cnt >= IPD_C)) begin
          state_d = ST_TX;
          exp_d   = expect_rsp_i;
        end
      end
      ST_RX: begin
        if (rx_end) state_d = ST_IDLE;
      end
      ST_TX: begin
        if (tx_done_i) state_d = ST_TURN;
      end
      ST_TURN: begin
        if (bit_cnt >= TURN_LAST_C) state_d = exp_q ? ST_WAIT : ST_IDLE;
      end
      ST_WAIT: begin
        if (rx_start) begin
          state_d = ST_RX;
          exp_d   = 1'b0;
        end else if (bit_cnt >= TIMEOUT_LAST_C) begin
          state_d   = ST_IDLE;
          exp_d     = 1'b0;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase

    if (force_off) begin
      state_d   = ST_OFF;
      exp_d     = 1'b0;
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_OFF;
      exp_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else if (clk_gate_i) begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      timeout_q <= timeout_d;
    end
  end

  assign rx_en_o      = (state_q == ST_IDLE) || (state_q == ST_RX) || (state_q == ST_WAIT);
  assign tx_grant_o   = (state_q == ST_TX);
  assign rx_active_o  = (state_q == ST_RX);
  assign rx_timeout_o = timeout_q;

endmodule

// File: doc/phy_arb.md
Name: phy_arb

Overview:
- Half-duplex bus arbiter and sequencer between the USB full-speed receiver (phy_rx) and transmitter (phy_tx).
- Gates rx_en to the receiver and grants the bus to the SIE for transmission.
- Enforces inter-packet delay and turnaround, and times out a pending handshake response.
- Sits between the SIE and the two PHY halves; all state is updated on clk_gate_i (one bit time).

Parameters:
IPD_BITS, 2, minimum bit times between end of a received packet (or own TX) and the next tx_grant_o.
TURN_BITS, 1, bit times rx_en_o stays low after tx_done_i, to mask own EOP echo.
TIMEOUT_BITS, 18, bit times waited for a response after a TX with expect_rsp_i set.

Ports:
clk_i  in  1  clock, 12MHz*BIT_SAMPLES.
rstn_i  in  1  asynchronous active-low reset.
clk_gate_i  in  1  one-clk pulse per bit time; all registers update only when high.
enable_i  in  1  arbiter enable; low forces ST_OFF.
bus_reset_i  in  1  bus reset from phy_rx; high forces ST_OFF.
rx_en_o  out  1  receiver enable to phy_rx.
rx_ready_i  in  1  phy_rx strobe.
rx_valid_i  in  1  phy_rx data-valid.
rx_err_i  in  1  phy_rx error.
tx_req_i  in  1  SIE transmit request; held until tx_grant_o.
expect_rsp_i  in  1  sampled with tx_req_i; a response is expected after this TX.
tx_grant_o  out  1  bus granted to transmitter; high for the whole TX.
tx_done_i  in  1  phy_tx finished EOP (one gated period pulse).
rx_active_o  out  1  packet reception in progress.
rx_timeout_o  out  1  one gated-period pulse on response timeout.

Behaviour:
- Reset values:
  - State ST_OFF.
  - rx_en_o=0, tx_grant_o=0, rx_active_o=0, rx_timeout_o=0.
  - bit_cnt=0, exp_q=0.
- Clock gating: all state and outputs change only on clk_i edges with clk_gate_i=1.
- Event decode:
  - RX EOP = rx_ready_i & ~rx_valid_i & ~rx_err_i.
  - RX end = EOP or (rx_ready_i & rx_err_i).
  - RX start = rx_ready_i & rx_valid_i.
- Counter:
  - bit_cnt width ceil_log2(max(IPD_BITS,TURN_BITS,TIMEOUT_BITS)+1).
  - Saturating increment.
  - Cleared on every state entry.
- States:
  - ST_OFF:
    - rx_en_o=0; grant=0.
    - Leave when enable_i & ~bus_reset_i, going to ST_IDLE with bit_cnt=0.
  - ST_IDLE:
    - rx_en_o=1; bit_cnt counts (saturates at IPD_BITS).
    - RX start -> ST_RX.
    - Else tx_req_i & bit_cnt>=IPD_BITS -> ST_TX; latch exp_q=expect_rsp_i.
  - ST_RX:
    - rx_en_o=1; rx_active_o=1.
    - RX end -> ST_IDLE, bit_cnt=0, so the IPD is re-timed from EOP.
  - ST_TX:
    - rx_en_o=0; tx_grant_o=1.
    - tx_done_i -> ST_TURN.
  - ST_TURN:
    - rx_en_o=0; grant=0.
    - After TURN_BITS gated periods: exp_q ? ST_WAIT : ST_IDLE (bit_cnt=0).
  - ST_WAIT:
    - rx_en_o=1; counts.
    - RX start -> ST_RX, clear exp_q.
    - bit_cnt==TIMEOUT_BITS-1 with no RX start -> rx_timeout_o=1 for one gated period, then ST_IDLE, clear exp_q.
    - tx_req_i is ignored here.
- Priorities, same gated cycle:
  - ~enable_i or bus_reset_i beats everything.
  - RX start beats tx_req_i.
  - RX start beats timeout.
- Aborts:
  - bus_reset_i during ST_TX drops tx_grant_o next gated cycle.
  - The SIE must treat a grant drop without tx_done_i as abort.
  - bus_reset_i during ST_RX drops rx_active_o.
- Spurious strobes:
  - tx_done_i outside ST_TX is ignored.
  - rx_ready_i in ST_TX/ST_TURN is ignored (rx_en_o low).
- Illegal state encoding -> ST_OFF.

Decomposition:
- Shared package holds:
  - State localparams ST_OFF..ST_WAIT (3-bit).
  - Default timing constants IPD_BITS/TURN_BITS/TIMEOUT_BITS.
  - The ceil_log2 function, shared with phy_rx/phy_tx.
- No sub-module needed; optionally factor the saturating bit-time counter as phy_bit_timer.

Test Plan:
- Reset, then enable_i=1 -> next gated cycle ST_IDLE, rx_en_o=1, tx_grant_o=0.
- RX packet: RX start, 3 bytes, then EOP; tx_req_i raised in the same cycle as EOP -> tx_grant_o rises exactly IPD_BITS+1 gated cycles after EOP, rx_en_o=0 while granted.
- TX with expect_rsp_i=1, tx_done_i, no response -> rx_en_o low for 1 bit time, then high; rx_timeout_o pulses once exactly 18 gated cycles later; state returns to ST_IDLE.
- Same as the previous case, but RX start at bit 17 of ST_WAIT -> no rx_timeout_o; rx_active_o=1 until EOP.
- tx_req_i and RX start in the same gated cycle in ST_IDLE (IPD satisfied) -> rx_active_o=1, tx_grant_o stays 0 until EOP + IPD_BITS.
- bus_reset_i=1 mid-TX -> tx_grant_o=0 and rx_en_o=0 next gated cycle; after bus_reset_i=0 -> ST_IDLE, rx_en_o=1.
